// File: rtl/ika9958_regfile_ctrl.sv
// IKA9958 VDP control-register file: port #1 two-byte register/VRAM-address
// sequencer, port #3 indirect writes through the R#17 pointer, decoded fields.
module ika9958_regfile_ctrl #(
  parameter int         NREG   = 48,
  parameter logic [7:0] R9_RST = 8'h00
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             P1_WR,
  input  logic             P3_WR,
  input  logic             P1_RD,
  input  logic [7:0]       DIN,
  output logic [63:0][7:0] FILE,
  output logic [4:0]       M,
  output logic             DC,
  output logic             NT_n,
  output logic             IL,
  output logic [1:0]       S,
  output logic [3:0]       H,
  output logic [3:0]       V,
  output logic             REG_WE,
  output logic [5:0]       REG_IDX,
  output logic             VA_SET,
  output logic [7:0]       VA_LO,
  output logic [7:0]       VA_HI
);

  localparam logic [6:0]  NREG_W = 7'(NREG);
  localparam int unsigned NREG_U = NREG;
  localparam logic [5:0]  PTR_IDX = 6'd17;

  typedef enum logic {FIRST, SECOND} p1_state_e;

  p1_state_e  state, state_nxt;
  logic [7:0] latch_q;
  logic [7:0] r17_q;
  logic [7:0] store [64];

  logic       p1_go, p3_go;
  logic       latch_en, st_we, we_nxt, r17_load, r17_inc, va_nxt;
  logic [5:0] wr_idx;
  logic [7:0] wr_data;

  function automatic logic implemented(input logic [5:0] idx);
    return {1'b0, idx} < NREG_W;
  endfunction

  // Read strobe cancels a same-cycle write; any port #1 write drops port #3.
  assign p1_go = P1_WR && !P1_RD;
  assign p3_go = P3_WR && !P1_WR;

  always_ff @(posedge CLK) begin
    if (RST) state <= FIRST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (P1_RD)      state_nxt = FIRST;
    else if (P1_WR) state_nxt = (state == FIRST) ? SECOND : FIRST;
  end

  always_comb begin
    latch_en = 1'b0;
    st_we    = 1'b0;
    we_nxt   = 1'b0;
    r17_load = 1'b0;
    r17_inc  = 1'b0;
    va_nxt   = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    if (state == FIRST) begin
      latch_en = p1_go;
    end else if (p1_go) begin
      if (DIN[7:6] == 2'b10) begin
        wr_idx   = DIN[5:0];
        wr_data  = latch_q;
        we_nxt   = implemented(DIN[5:0]);
        // R17 lives outside the store so it exists even when NREG <= 17.
        r17_load = (DIN[5:0] == PTR_IDX);
        st_we    = we_nxt && !r17_load;
      end else if (!DIN[7]) begin
        va_nxt = 1'b1;
      end
    end
    if (p3_go) begin
      wr_idx  = r17_q[5:0];
      wr_data = DIN;
      we_nxt  = implemented(r17_q[5:0]) && (r17_q[5:0] != PTR_IDX);
      st_we   = we_nxt;
      r17_inc = !r17_q[7];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)           latch_q <= '0;
    else if (latch_en) latch_q <= DIN;
  end

  always_ff @(posedge CLK) begin
    if (RST)           r17_q <= '0;
    else if (r17_load) r17_q <= latch_q;
    else if (r17_inc)  r17_q[5:0] <= r17_q[5:0] + 6'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 64; i++)
        store[i[5:0]] <= (i == 9) ? R9_RST : '0;
    end else if (st_we) begin
      store[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      REG_WE  <= 1'b0;
      REG_IDX <= '0;
      VA_SET  <= 1'b0;
      VA_LO   <= '0;
      VA_HI   <= '0;
    end else begin
      REG_WE <= we_nxt;
      VA_SET <= va_nxt;
      if (we_nxt) REG_IDX <= wr_idx;
      if (va_nxt) begin
        VA_LO <= latch_q;
        VA_HI <= DIN;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= NREG_U)  FILE[i[5:0]] = '0;
      else if (i == 17) FILE[i[5:0]] = r17_q;
      else              FILE[i[5:0]] = store[i[5:0]];
    end
  end

  assign M    = {FILE[0][3:1], FILE[1][3], FILE[1][4]};
  assign DC   = FILE[9][0];
  assign NT_n = FILE[9][1];
  assign IL   = FILE[9][3];
  assign S    = FILE[9][5:4];
  assign H    = FILE[18][3:0];
  assign V    = FILE[18][7:4];

endmodule

// File: tb/tb_ika9958_regfile_ctrl.sv
// Directed bench for ika9958_regfile_ctrl with hand-computed expectations.
module tb_ika9958_regfile_ctrl;

  logic             clk = 1'b0;
  logic             rst, p1_wr, p3_wr, p1_rd;
  logic [7:0]       din;
  logic [63:0][7:0] file;
  logic [4:0]       m;
  logic             dc, nt_n, il;
  logic [1:0]       s;
  logic [3:0]       h, v;
  logic             reg_we;
  logic [5:0]       reg_idx;
  logic             va_set;
  logic [7:0]       va_lo, va_hi;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ika9958_regfile_ctrl #(.NREG(48), .R9_RST(8'h02)) dut (
    .CLK(clk), .RST(rst), .P1_WR(p1_wr), .P3_WR(p3_wr), .P1_RD(p1_rd),
    .DIN(din), .FILE(file), .M(m), .DC(dc), .NT_n(nt_n), .IL(il), .S(s),
    .H(h), .V(v), .REG_WE(reg_we), .REG_IDX(reg_idx), .VA_SET(va_set),
    .VA_LO(va_lo), .VA_HI(va_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p1w(input logic [7:0] d);
    p1_wr = 1'b1; din = d;
    tick();
    p1_wr = 1'b0;
  endtask

  task automatic p3w(input logic [7:0] d);
    p3_wr = 1'b1; din = d;
    tick();
    p3_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; p1_wr = 1'b0; p3_wr = 1'b0; p1_rd = 1'b0; din = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_r9", file[9], 8'h02);
    check("rst_ntn", nt_n, 1'b1);
    check("rst_m", m, 5'b0);
    check("rst_r0", file[0], 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_va", va_set, 1'b0);

    // Direct register write R0 = 0x0E
    p1w(8'h0E);
    check("first_no_we", reg_we, 1'b0);
    p1w(8'h80);
    check("r0_we", reg_we, 1'b1);
    check("r0_idx", reg_idx, 6'd0);
    check("r0_val", file[0], 8'h0E);
    check("r0_m", m, 5'b11100);
    tick();
    check("we_pulse", reg_we, 1'b0);

    // VRAM address setup
    p1w(8'h34);
    p1w(8'h45);
    check("va_set", va_set, 1'b1);
    check("va_lo", va_lo, 8'h34);
    check("va_hi", va_hi, 8'h45);
    check("va_no_we", reg_we, 1'b0);
    check("va_r0", file[0], 8'h0E);
    tick();
    check("va_pulse", va_set, 1'b0);

    // Status read resets the sequence
    p1w(8'hAA);
    p1_rd = 1'b1; tick(); p1_rd = 1'b0;
    p1w(8'h81);
    check("rd_no_we", reg_we, 1'b0);
    check("rd_r1", file[1], 8'h00);
    p1w(8'h81);
    check("rd_r1_after", file[1], 8'h81);
    check("rd_idx", reg_idx, 6'd1);

    // Pointer wrap through unimplemented 62/63
    p1w(8'h3E); p1w(8'h91);
    check("r17_dir", file[17], 8'h3E);
    check("r17_idx", reg_idx, 6'd17);
    p3w(8'h11);
    check("p3_62_we", reg_we, 1'b0);
    check("p3_62_ptr", file[17], 8'h3F);
    p3w(8'h22);
    check("p3_63_we", reg_we, 1'b0);
    check("p3_wrap", file[17], 8'h00);
    p3w(8'h33);
    check("p3_0_we", reg_we, 1'b1);
    check("p3_0_idx", reg_idx, 6'd0);
    check("p3_0_val", file[0], 8'h33);
    check("p3_0_ptr", file[17], 8'h01);
    check("f62", file[62], 8'h00);
    check("f63", file[63], 8'h00);

    // No-increment mode, and discarded write to R17
    p1w(8'h90); p1w(8'h91);
    p3w(8'h5A); p3w(8'h5A);
    check("noinc_val", file[16], 8'h5A);
    check("noinc_idx", reg_idx, 6'd16);
    check("noinc_ptr", file[17], 8'h90);
    p1w(8'h11); p1w(8'h91);
    p3w(8'hFF);
    check("p3_17_we", reg_we, 1'b0);
    check("p3_17_ptr", file[17], 8'h12);

    // Simultaneous port #1 and port #3
    p1w(8'h05); p1w(8'h91);
    p1w(8'h77);
    p1_wr = 1'b1; p3_wr = 1'b1; din = 8'h92;
    tick();
    p1_wr = 1'b0; p3_wr = 1'b0;
    check("sim_r18", file[18], 8'h77);
    check("sim_h", h, 4'h7);
    check("sim_v", v, 4'h7);
    check("sim_idx", reg_idx, 6'd18);
    check("sim_r5", file[5], 8'h00);
    check("sim_ptr", file[17], 8'h05);

    // Same-cycle write and read: read wins
    p1w(8'h12);
    p1_wr = 1'b1; p1_rd = 1'b1; din = 8'h85;
    tick();
    p1_wr = 1'b0; p1_rd = 1'b0;
    check("wrrd_we", reg_we, 1'b0);
    check("wrrd_r5", file[5], 8'h00);
    p1w(8'h66); p1w(8'h85);
    check("wrrd_after", file[5], 8'h66);

    // NREG boundary
    p1w(8'hAB); p1w(8'hB0);
    check("r48_we", reg_we, 1'b0);
    check("r48_val", file[48], 8'h00);
    p1w(8'hAB); p1w(8'hAF);
    check("r47_we", reg_we, 1'b1);
    check("r47_val", file[47], 8'hAB);

    // Reserved second byte
    p1w(8'hCC); p1w(8'hC3);
    check("rsv_we", reg_we, 1'b0);
    check("rsv_va", va_set, 1'b0);
    check("rsv_r3", file[3], 8'h00);

    // R9 decoded fields
    p1w(8'h3B); p1w(8'h89);
    check("r9_dc", dc, 1'b1);
    check("r9_ntn", nt_n, 1'b1);
    check("r9_il", il, 1'b1);
    check("r9_s", s, 2'b11);

    // Reset in mid-sequence, overriding a same-cycle strobe
    p1w(8'h55);
    rst = 1'b1; p1_wr = 1'b1; din = 8'h89;
    tick();
    rst = 1'b0; p1_wr = 1'b0;
    check("mrst_r9", file[9], 8'h02);
    check("mrst_r18", file[18], 8'h00);
    check("mrst_we", reg_we, 1'b0);
    check("mrst_ptr", file[17], 8'h00);
    p1w(8'h8F);
    check("mrst_first", reg_we, 1'b0);
    check("mrst_r15", file[15], 8'h00);
    p1w(8'h87);
    check("mrst_r7", file[7], 8'h8F);
    check("mrst_idx", reg_idx, 6'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
